// File: rtl/cvm300_pkg.sv
// rtl/cvm300_pkg.sv - shared types, constants and lane helper for the CVM300 frame capture path
package cvm300_pkg;

    localparam int WORD_BITS        = 32;
    localparam int FRAME_PIXELS_DEF = 316224;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_DATA,
        CAPTURE,
        FLUSH
    } state_t;

    // Places a zero-extended pixel into its lane of a partially built word.
    function automatic logic [WORD_BITS-1:0] lane_insert(
        input logic [WORD_BITS-1:0] word,
        input logic [WORD_BITS-1:0] pix,
        input int                   shift
    );
        return word | (pix << shift);
    endfunction

endpackage

// File: rtl/cvm300_frame_capture_if.sv
// rtl/cvm300_frame_capture_if.sv - sensor pixel bus and downstream FIFO write port
interface cvm300_frame_capture_if;

    logic        CVM300_Line_valid;
    logic        CVM300_Data_valid;
    logic [9:0]  CVM300_D;
    logic        CVM300_FRAME_REQ;
    logic [31:0] fifo_din;
    logic        fifo_wr_en;
    logic        fifo_full;

    modport master (
        input  CVM300_Line_valid, CVM300_Data_valid, CVM300_D, fifo_full,
        output CVM300_FRAME_REQ, fifo_din, fifo_wr_en
    );

    modport slave (
        output CVM300_Line_valid, CVM300_Data_valid, CVM300_D, fifo_full,
        input  CVM300_FRAME_REQ, fifo_din, fifo_wr_en
    );

endinterface

// File: rtl/cvm300_pixel_packer.sv
// rtl/cvm300_pixel_packer.sv - packs pixels into 32-bit words, flushes zero-padded partial words
module cvm300_pixel_packer
    import cvm300_pkg::*;
#(
    parameter int PIXEL_BITS      = 8,
    parameter int PIXELS_PER_WORD = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  pix_valid,
    input  logic [PIXEL_BITS-1:0] pix_data,
    input  logic                  flush,
    input  logic                  fifo_full,
    output logic [WORD_BITS-1:0]  word,
    output logic                  word_wr,
    output logic                  word_drop
);

    localparam int LW = 3;

    logic [LW-1:0]        lane;
    logic [WORD_BITS-1:0] acc;
    logic [WORD_BITS-1:0] acc_ins;
    logic                 last_lane;
    logic                 emit;

    always_comb begin
        acc_ins   = lane_insert(acc, WORD_BITS'(pix_data), int'(lane) * PIXEL_BITS);
        last_lane = (lane == LW'(PIXELS_PER_WORD - 1));
        // A flush only emits when lanes are pending; an empty accumulator stays silent.
        emit      = !clear && ((pix_valid && last_lane) || (!pix_valid && flush && lane != '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane      <= '0;
            acc       <= '0;
            word      <= '0;
            word_wr   <= 1'b0;
            word_drop <= 1'b0;
        end else begin
            word_wr   <= emit && !fifo_full;
            word_drop <= emit && fifo_full;
            if (emit && !fifo_full) begin
                word <= pix_valid ? acc_ins : acc;
            end
            if (clear || emit) begin
                lane <= '0;
                acc  <= '0;
            end else if (pix_valid) begin
                lane <= lane + LW'(1);
                acc  <= acc_ins;
            end
        end
    end

endmodule

// File: rtl/cvm300_frame_capture.sv
// rtl/cvm300_frame_capture.sv - CVM300 frame request/capture FSM; CAPTURE_TEST_PATTERN_EN selects counter pixels
module cvm300_frame_capture
    import cvm300_pkg::*;
#(
    parameter int PIXEL_BITS      = 8,
    parameter int PIXELS_PER_WORD = 4,
    parameter int FRAME_PIXELS    = FRAME_PIXELS_DEF,
    parameter int REQ_CYCLES      = 2
) (
    input  logic                  CVM300_CLK_OUT,
    input  logic                  SYS_RES_N,
    input  logic                  start,
    input  logic                  abort,
    input  logic [15:0]           frame_count,
    cvm300_frame_capture_if.master bus,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overflow,
    output logic [15:0]           frames_captured
);

    localparam int PCW = $clog2(FRAME_PIXELS + 1);
    localparam int RCW = $clog2(REQ_CYCLES + 1);

    state_t                state;
    state_t                next_state;
    logic [RCW-1:0]        req_cnt;
    logic [PCW-1:0]        pix_cnt;
    logic                  start_go;
    logic                  pix_in;
    logic                  last_pix;
    logic [15:0]           frames_next;
    logic [PIXEL_BITS-1:0] pix_data;
    logic                  word_drop;
    logic                  unused_d;

    assign unused_d = ^bus.CVM300_D;

    always_comb begin
        start_go    = start && !abort && (state == IDLE);
        pix_in      = bus.CVM300_Line_valid && bus.CVM300_Data_valid && !abort &&
                      ((state == WAIT_DATA) || (state == CAPTURE));
        last_pix    = pix_in && (pix_cnt == PCW'(FRAME_PIXELS - 1));
        frames_next = (frames_captured == 16'hFFFF) ? frames_captured : frames_captured + 16'd1;
    end

`ifdef CAPTURE_TEST_PATTERN_EN
    assign pix_data = PIXEL_BITS'(pix_cnt);
`else
    assign pix_data = bus.CVM300_D[PIXEL_BITS-1:0];
`endif

    always_ff @(posedge CVM300_CLK_OUT or negedge SYS_RES_N) begin
        if (!SYS_RES_N) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:      if (start) next_state = REQ;
                REQ:       if (req_cnt == RCW'(REQ_CYCLES - 1)) next_state = WAIT_DATA;
                WAIT_DATA: if (pix_in) next_state = last_pix ? FLUSH : CAPTURE;
                CAPTURE:   if (last_pix) next_state = FLUSH;
                FLUSH:     next_state = (frame_count == 16'd0 || frames_next < frame_count) ? REQ : IDLE;
                default:   next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        busy                 = (state != IDLE);
        frame_done           = (state == FLUSH) && !abort;
        bus.CVM300_FRAME_REQ = (state == REQ);
    end

    always_ff @(posedge CVM300_CLK_OUT or negedge SYS_RES_N) begin
        if (!SYS_RES_N) begin
            req_cnt         <= '0;
            pix_cnt         <= '0;
            frames_captured <= '0;
            overflow        <= 1'b0;
        end else begin
            req_cnt <= (state == REQ && !abort) ? req_cnt + RCW'(1) : '0;
            if (start_go || abort || state == FLUSH) begin
                pix_cnt <= '0;
            end else if (pix_in) begin
                pix_cnt <= pix_cnt + PCW'(1);
            end
            if (start_go) begin
                frames_captured <= '0;
            end else if (state == FLUSH && !abort) begin
                frames_captured <= frames_next;
            end
            if (start_go) begin
                overflow <= 1'b0;
            end else if (word_drop) begin
                overflow <= 1'b1;
            end
        end
    end

    cvm300_pixel_packer #(
        .PIXEL_BITS      (PIXEL_BITS),
        .PIXELS_PER_WORD (PIXELS_PER_WORD)
    ) u_packer (
        .clk       (CVM300_CLK_OUT),
        .rst_n     (SYS_RES_N),
        .clear     (abort || start_go),
        .pix_valid (pix_in),
        .pix_data  (pix_data),
        .flush     (state == FLUSH),
        .fifo_full (bus.fifo_full),
        .word      (bus.fifo_din),
        .word_wr   (bus.fifo_wr_en),
        .word_drop (word_drop)
    );

endmodule

// File: tb/tb_cvm300_frame_capture.sv
// tb/tb_cvm300_frame_capture.sv - scoreboard bench for cvm300_frame_capture in two parameter sets
module tb_cvm300_frame_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, abort_a, start_b, abort_b;
    logic [15:0] frame_count_a, frame_count_b;
    logic        busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
    logic [15:0] fc_a, fc_b;

    int n_checks = 0;
    int n_errors = 0;
    int n_done_a = 0, n_done_b = 0;
    int n_req_a = 0, n_req_b = 0;
    int req_w_a = 0, req_w_b = 0;
    int done_ref, req_ref;
    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];

    cvm300_frame_capture_if if_a ();
    cvm300_frame_capture_if if_b ();

    always #5 clk = ~clk;

    cvm300_frame_capture #(
        .PIXEL_BITS(8), .PIXELS_PER_WORD(4), .FRAME_PIXELS(8), .REQ_CYCLES(2)
    ) dut_a (
        .CVM300_CLK_OUT(clk), .SYS_RES_N(rst_n), .start(start_a), .abort(abort_a),
        .frame_count(frame_count_a), .bus(if_a), .busy(busy_a), .frame_done(done_a),
        .overflow(ovf_a), .frames_captured(fc_a)
    );

    cvm300_frame_capture #(
        .PIXEL_BITS(10), .PIXELS_PER_WORD(3), .FRAME_PIXELS(4), .REQ_CYCLES(2)
    ) dut_b (
        .CVM300_CLK_OUT(clk), .SYS_RES_N(rst_n), .start(start_b), .abort(abort_b),
        .frame_count(frame_count_b), .bus(if_b), .busy(busy_b), .frame_done(done_b),
        .overflow(ovf_b), .frames_captured(fc_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pk4(input int b);
        return {8'(b + 3), 8'(b + 2), 8'(b + 1), 8'(b)};
    endfunction

    always @(negedge clk) begin
        if (if_a.fifo_wr_en) begin
            chk("a_wr_expected", exp_a.size() != 0, 1);
            if (exp_a.size() != 0) chk("a_word", if_a.fifo_din, exp_a.pop_front());
        end
        if (if_b.fifo_wr_en) begin
            chk("b_wr_expected", exp_b.size() != 0, 1);
            if (exp_b.size() != 0) chk("b_word", if_b.fifo_din, exp_b.pop_front());
        end
        if (done_a) n_done_a++;
        if (done_b) n_done_b++;
        if (if_a.CVM300_FRAME_REQ) req_w_a++;
        else if (req_w_a != 0) begin chk("a_req_width", req_w_a, 2); n_req_a++; req_w_a = 0; end
        if (if_b.CVM300_FRAME_REQ) req_w_b++;
        else if (req_w_b != 0) begin chk("b_req_width", req_w_b, 2); n_req_b++; req_w_b = 0; end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic start_pulse_a();
        start_a = 1'b1; tick(); start_a = 1'b0;
    endtask

    // Waits out one FRAME_REQ pulse; optionally drives junk pixels that must be discarded.
    task automatic wait_req_a(input bit junk);
        bit seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (if_a.CVM300_FRAME_REQ) begin
                seen = 1'b1;
                if (junk) begin
                    if_a.CVM300_Line_valid = 1'b1; if_a.CVM300_Data_valid = 1'b1; if_a.CVM300_D = 10'h0EE;
                end
            end else if (seen) break;
            tick();
        end
        if_a.CVM300_Line_valid = 1'b0; if_a.CVM300_Data_valid = 1'b0;
        chk("a_req_seen", seen, 1);
    endtask

    task automatic send_a(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            if_a.CVM300_D = 10'(base + i);
            if_a.CVM300_Line_valid = 1'b1; if_a.CVM300_Data_valid = 1'b1;
            tick();
        end
        if_a.CVM300_Line_valid = 1'b0; if_a.CVM300_Data_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start_a = 0; abort_a = 0; start_b = 0; abort_b = 0;
        frame_count_a = 16'd1; frame_count_b = 16'd1;
        if_a.CVM300_Line_valid = 0; if_a.CVM300_Data_valid = 0; if_a.CVM300_D = 0; if_a.fifo_full = 0;
        if_b.CVM300_Line_valid = 0; if_b.CVM300_Data_valid = 0; if_b.CVM300_D = 0; if_b.fifo_full = 0;
        tick(3);
        chk("rst_busy", busy_a, 0);
        chk("rst_req", if_a.CVM300_FRAME_REQ, 0);
        chk("rst_wr", if_a.fifo_wr_en, 0);
        chk("rst_din", if_a.fifo_din, 0);
        chk("rst_ovf", ovf_a, 0);
        chk("rst_fc", fc_a, 0);
        rst_n = 1'b1;
        tick(2);

        // One 8-pixel frame, junk during REQ and extra pixels after the frame are discarded.
        exp_a.push_back(32'h04030201); exp_a.push_back(32'h08070605);
        start_pulse_a();
        wait_req_a(1'b1);
        send_a(8, 1);
        send_a(2, 9);
        tick(5);
        chk("t1_done", n_done_a, 1);
        chk("t1_fc", fc_a, 1);
        chk("t1_busy", busy_a, 0);
        chk("t1_q", exp_a.size(), 0);

        // Second word meets a full FIFO and is dropped.
        exp_a.push_back(32'h04030201);
        start_pulse_a();
        chk("t2_ovf_cleared", ovf_a, 0);
        wait_req_a(1'b0);
        send_a(4, 1);
        if_a.fifo_full = 1'b1;
        send_a(4, 5);
        tick(3);
        if_a.fifo_full = 1'b0;
        tick(3);
        chk("t2_ovf", ovf_a, 1);
        chk("t2_fc", fc_a, 1);
        chk("t2_q", exp_a.size(), 0);

        // Three-frame run; a start during WAIT_DATA must be ignored.
        frame_count_a = 16'd3;
        done_ref = n_done_a; req_ref = n_req_a;
        start_pulse_a();
        chk("t3_ovf_cleared", ovf_a, 0);
        for (int f = 0; f < 3; f++) begin
            exp_a.push_back(pk4(32 * f + 1)); exp_a.push_back(pk4(32 * f + 5));
            wait_req_a(1'b0);
            if (f == 1) start_pulse_a();
            send_a(8, 32 * f + 1);
        end
        tick(6);
        chk("t3_req_pulses", n_req_a - req_ref, 3);
        chk("t3_done", n_done_a - done_ref, 3);
        chk("t3_fc", fc_a, 3);
        chk("t3_busy", busy_a, 0);
        chk("t3_q", exp_a.size(), 0);

        // Abort after five pixels: first word only, no frame_done.
        frame_count_a = 16'd1;
        done_ref = n_done_a;
        exp_a.push_back(32'h04030201);
        start_pulse_a();
        wait_req_a(1'b0);
        send_a(5, 1);
        abort_a = 1'b1; tick(); abort_a = 1'b0;
        chk("t4_busy", busy_a, 0);
        chk("t4_req", if_a.CVM300_FRAME_REQ, 0);
        tick(5);
        chk("t4_no_done", n_done_a - done_ref, 0);
        chk("t4_q", exp_a.size(), 0);

        start_a = 1'b1; abort_a = 1'b1; tick(); start_a = 1'b0; abort_a = 1'b0;
        chk("t5_abort_wins", busy_a, 0);
        tick(2);

        // 10-bit pixels, three per word, flush pads the fourth pixel.
        exp_b.push_back(32'h3FFFFFFF); exp_b.push_back(32'h000003FF);
        start_b = 1'b1; tick(); start_b = 1'b0;
        for (int k = 0; k < 50 && !(req_w_b == 0 && n_req_b == 1); k++) tick();
        chk("b_req_seen", n_req_b, 1);
        for (int i = 0; i < 4; i++) begin
            if_b.CVM300_D = 10'h3FF; if_b.CVM300_Line_valid = 1'b1; if_b.CVM300_Data_valid = 1'b1;
            tick();
        end
        if_b.CVM300_Line_valid = 1'b0; if_b.CVM300_Data_valid = 1'b0;
        tick(6);
        chk("b_done", n_done_b, 1);
        chk("b_fc", fc_b, 1);
        chk("b_busy", busy_b, 0);
        chk("b_q", exp_b.size(), 0);

        // Reset in the middle of a continuous run.
        frame_count_a = 16'd0;
        exp_a.push_back(32'h04030201);
        start_pulse_a();
        wait_req_a(1'b0);
        send_a(6, 1);
        chk("t6_busy_pre", busy_a, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_busy", busy_a, 0);
        chk("t6_wr", if_a.fifo_wr_en, 0);
        chk("t6_din", if_a.fifo_din, 0);
        chk("t6_req", if_a.CVM300_FRAME_REQ, 0);
        chk("t6_done", done_a, 0);
        chk("t6_fc", fc_a, 0);
        tick(3);
        rst_n = 1'b1;
        tick(5);
        chk("t6_q", exp_a.size(), 0);
        chk("t6_busy_post", busy_a, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cvm300_frame_capture.md
CVM300_FRAME_CAPTURE -- requirements
Module: cvm300_frame_capture

Interface
REQ-001 SHALL have parameter PIXEL_BITS, default 8, stored bits per pixel (1..10, taken from CVM300_D LSBs).
REQ-002 SHALL have parameter PIXELS_PER_WORD, default 4, pixels packed per 32-bit output word (1..4, PIXEL_BITS*PIXELS_PER_WORD <= 32).
REQ-003 SHALL have parameter FRAME_PIXELS, default 316224, valid pixels per frame.
REQ-004 SHALL have parameter REQ_CYCLES, default 2, FRAME_REQ high width in clocks.
REQ-005 SHALL have these ports (name  direction  width  meaning), one per line:
 CVM300_CLK_OUT  in  1  sensor output clock; the only clock, rising edge.
 SYS_RES_N  in  1  asynchronous active-low reset.
 start  in  1  one-cycle capture start pulse.
 abort  in  1  one-cycle abort pulse.
 frame_count  in  16  frames per run; 0 = continuous.
 CVM300_Line_valid  in  1  LVAL.
 CVM300_Data_valid  in  1  DVAL.
 CVM300_D  in  10  pixel data.
 fifo_full  in  1  downstream FIFO full.
 CVM300_FRAME_REQ  out  1  frame request to sensor.
 fifo_din  out  32  packed word.
 fifo_wr_en  out  1  write strobe, one word per high cycle.
 busy  out  1  FSM not IDLE.
 frame_done  out  1  one-cycle pulse per completed frame.
 overflow  out  1  sticky, word dropped on fifo_full.
 frames_captured  out  16  completed frames this run.

Function
REQ-006 SHALL implement FSM states IDLE, REQ, WAIT_DATA, CAPTURE, FLUSH.
REQ-007 IDLE->REQ on start; start outside IDLE SHALL be ignored.
REQ-008 REQ SHALL drive CVM300_FRAME_REQ high for exactly REQ_CYCLES clocks, then enter WAIT_DATA.
REQ-009 WAIT_DATA->CAPTURE on the first cycle LVAL&DVAL=1; that pixel SHALL be captured.
REQ-010 A pixel SHALL be accepted only when LVAL&DVAL=1 in WAIT_DATA or CAPTURE; CVM300_D[PIXEL_BITS-1:0] zero-extended.
REQ-011 Packing: first pixel of a word at bits [PIXEL_BITS-1:0], lane k at [k*PIXEL_BITS +: PIXEL_BITS], unused MSBs zero.
REQ-012 fifo_wr_en SHALL pulse one clock after the accepting cycle of a word's last pixel (latency 1), with fifo_din valid in that cycle.
REQ-013 The pixel counter SHALL count accepted pixels; at FRAME_PIXELS the FSM enters FLUSH.
REQ-014 FLUSH SHALL emit any partial word zero-padded in upper lanes, pulse frame_done, and increment frames_captured (saturating at 0xFFFF).
REQ-015 After FLUSH: if frame_count=0 or frames_captured<frame_count, go to REQ; else go to IDLE.
REQ-016 Accepted pixels beyond FRAME_PIXELS and pixels in IDLE/REQ/FLUSH SHALL be discarded.
REQ-017 If fifo_full=1 when a word is due, the word SHALL be dropped, fifo_wr_en held low, and overflow set until the next start.
REQ-018 abort in any state SHALL go to IDLE next clock: partial word discarded, FRAME_REQ low, no frame_done.
REQ-019 abort and start in the same cycle: abort wins.
REQ-020 start SHALL clear overflow, frames_captured, the pixel counter, and the packing lane.

Reset
REQ-021 SYS_RES_N low SHALL asynchronously force IDLE; all outputs and counters 0; deassertion is synchronised by the integrator.
REQ-022 Reset mid-frame SHALL drop the partial word and never emit a spurious fifo_wr_en.

Configuration
REQ-023 With CAPTURE_TEST_PATTERN_EN defined, each accepted pixel SHALL be replaced by (pixel counter mod 2^PIXEL_BITS) with identical timing; without it, sensor data SHALL be used and no pattern logic built.

Structure
REQ-024 Shared package cvm300_pkg SHALL hold the FSM state enum, FRAME_PIXELS default and word width 32.
REQ-025 One sub-module, cvm300_pixel_packer (lane register, lane counter, flush/pad), SHALL be natural; the FSM and counters stay in the top.

Verification
REQ-026 PIXEL_BITS=8, PPW=4, FRAME_PIXELS=8, pixels 0x01..0x08 -> words 0x04030201, 0x08070605; one frame_done.
REQ-027 PIXEL_BITS=10, PPW=3, FRAME_PIXELS=4, pixels 0x3FF x4 -> words 0x3FFFFFFF, 0x000003FF (flush pad).
REQ-028 fifo_full high during second word of REQ-026 -> only 0x04030201 written; overflow=1 until next start.
REQ-029 frame_count=3, REQ_CYCLES=2 -> three 2-cycle FRAME_REQ pulses; frames_captured=3; return to IDLE.
REQ-030 abort after 5 of 8 pixels -> 1 word written, no frame_done, busy=0 next cycle; SYS_RES_N low mid-frame -> all outputs 0 at once.
